// File: rtl/ddram_arb.sv
// ddram_arb: two-port arbiter in front of a DDRAM burst interface.
// Port 0 issues video burst reads, port 1 single-word reads/writes. Port 0 has
// priority, but port 1 is guaranteed a grant after P0_STREAK consecutive port-0
// grants taken while it was waiting. Only one transaction is in flight at a time.
//
// state | meaning
// IDLE  | no transaction; arbitrate between p0_req and p1_req
// CMD   | command registers drive DDRAM until DDRAM_BUSY is sampled low
// RDATA | counting read beats and routing them to the granted port
module ddram_arb #(
  parameter int P0_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_req,
  input  logic [28:0] p0_addr,
  input  logic [7:0]  p0_len,
  output logic        p0_ack,
  output logic [63:0] p0_data,
  output logic        p0_valid,
  output logic        p0_done,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [28:0] p1_addr,
  input  logic [63:0] p1_din,
  input  logic [7:0]  p1_be,
  output logic        p1_ack,
  output logic [63:0] p1_dout,
  output logic        p1_valid,

  input  logic        DDRAM_BUSY,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE
);

  typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;

  localparam int SW = $clog2(P0_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(P0_STREAK);

  state_t        state;
  logic [SW-1:0] streak;
  logic          owner;      // 0 = port 0 owns the transaction, 1 = port 1
  logic [7:0]    beat_cnt;
  logic          grant_p0;
  logic          grant_p1;
  logic [7:0]    p0_cnt;

  // Arbitration decision: port 1 only wins over a requesting port 0 once the streak is exhausted
  always_comb begin
    grant_p1 = p1_req && (!p0_req || (streak == STREAK_MAX));
    grant_p0 = p0_req && !grant_p1;
    p0_cnt   = (p0_len == 8'd0) ? 8'd1 : p0_len;
  end

  // Sequencer: grant, command hold until accepted, then read-beat collection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      streak         <= '0;
      owner          <= 1'b0;
      beat_cnt       <= 8'd0;
      p0_ack         <= 1'b0;
      p0_data        <= 64'd0;
      p0_valid       <= 1'b0;
      p0_done        <= 1'b0;
      p1_ack         <= 1'b0;
      p1_dout        <= 64'd0;
      p1_valid       <= 1'b0;
      DDRAM_BURSTCNT <= 8'd1;
      DDRAM_ADDR     <= 29'd0;
      DDRAM_DIN      <= 64'd0;
      DDRAM_BE       <= 8'd0;
      DDRAM_RD       <= 1'b0;
      DDRAM_WE       <= 1'b0;
    end else begin
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_valid <= 1'b0;
      p0_done  <= 1'b0;
      p1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_p1) begin
            owner          <= 1'b1;
            p1_ack         <= 1'b1;
            DDRAM_ADDR     <= p1_addr;
            DDRAM_BURSTCNT <= 8'd1;
            DDRAM_DIN      <= p1_din;
            DDRAM_BE       <= p1_we ? p1_be : 8'hFF;
            DDRAM_WE       <= p1_we;
            DDRAM_RD       <= !p1_we;
            streak         <= '0;
            beat_cnt       <= 8'd0;
            state          <= CMD;
          end else if (grant_p0) begin
            owner          <= 1'b0;
            p0_ack         <= 1'b1;
            DDRAM_ADDR     <= p0_addr;
            DDRAM_BURSTCNT <= p0_cnt;
            DDRAM_DIN      <= 64'd0;
            DDRAM_BE       <= 8'hFF;
            DDRAM_WE       <= 1'b0;
            DDRAM_RD       <= 1'b1;
            beat_cnt       <= 8'd0;
            state          <= CMD;
            if (!p1_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + SW'(1);
          end
        end
        CMD: begin
          if (!DDRAM_BUSY && (DDRAM_RD || DDRAM_WE)) begin
            DDRAM_RD <= 1'b0;
            DDRAM_WE <= 1'b0;
            state    <= DDRAM_WE ? IDLE : RDATA;
          end
        end
        RDATA: begin
          if (DDRAM_DOUT_READY) begin
            if (owner) begin
              p1_valid <= 1'b1;
              p1_dout  <= DDRAM_DOUT;
            end else begin
              p0_valid <= 1'b1;
              p0_data  <= DDRAM_DOUT;
            end
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt + 8'd1 == DDRAM_BURSTCNT) begin
              p0_done <= !owner;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_arb.sv
// tb_ddram_arb: self-checking bench for ddram_arb with a behavioural DDRAM,
// an independent reference memory and a plain arithmetic arbitration model.
`timescale 1ns/1ps
module tb_ddram_arb;
  localparam int P0_STREAK = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req;
  logic [28:0] p0_addr;
  logic [7:0]  p0_len;
  logic        p0_ack;
  logic [63:0] p0_data;
  logic        p0_valid;
  logic        p0_done;
  logic        p1_req;
  logic        p1_we;
  logic [28:0] p1_addr;
  logic [63:0] p1_din;
  logic [7:0]  p1_be;
  logic        p1_ack;
  logic [63:0] p1_dout;
  logic        p1_valid;
  logic        DDRAM_BUSY;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_RD;
  logic        DDRAM_WE;

  int errors = 0;
  int checks = 0;

  ddram_arb #(.P0_STREAK(P0_STREAK)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_len(p0_len), .p0_ack(p0_ack),
    .p0_data(p0_data), .p0_valid(p0_valid), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
    .p1_be(p1_be), .p1_ack(p1_ack), .p1_dout(p1_dout), .p1_valid(p1_valid),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE), .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE)
  );

  always #5 clk = ~clk;

  // memories: ddr_mem is written by what the DUT drives, ref_mem by what the bench requested
  logic [63:0] ddr_mem [logic [28:0]];
  logic [63:0] ref_mem [logic [28:0]];

  function automatic logic [63:0] init_word(input logic [28:0] a);
    return {a ^ 29'h0ABCDEF1, 6'h2A, a};
  endfunction
  function automatic logic [63:0] ddr_rd(input logic [28:0] a);
    return ddr_mem.exists(a) ? ddr_mem[a] : init_word(a);
  endfunction
  function automatic logic [63:0] ref_rd(input logic [28:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] din,
                                        input logic [7:0] be);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = be[i] ? din[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

  typedef struct {
    logic [28:0] addr;
    logic [7:0]  cnt;
    logic        we;
    logic [63:0] din;
    logic [7:0]  be;
  } cmd_t;

  // bus model controls and observation logs
  bit          rand_busy = 0;
  bit          rand_gap = 0;
  int          busy_cnt = 0;
  int          junk_ready = 0;
  logic [63:0] rq[$];
  cmd_t        acc_q[$];
  logic [63:0] p0_beats[$];
  bit          p0_dones[$];
  logic [63:0] p1_beats[$];
  int          grants[$];
  int          grant_cyc[$];
  int          p0_done_cyc = 0;
  int          ack_cycles = 0, rd_cycles = 0, we_cycles = 0, we_unstable = 0, we_run = 0;
  int          stray_done = 0, done_cnt = 0, cyc = 0;
  int          m_streak = 0;
  logic [63:0] we_din;
  logic [7:0]  we_be;

  // DDRAM responder and output monitor; samples at negedge, drives after posedge
  initial begin : bus_model
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = 64'd0; DDRAM_DOUT_READY = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rq.delete();
        we_run = 0;
      end else if (DDRAM_RD || DDRAM_WE) begin
        if (DDRAM_RD) rd_cycles++;
        if (DDRAM_WE) begin
          we_cycles++;
          if (we_run > 0 && (DDRAM_DIN !== we_din || DDRAM_BE !== we_be)) we_unstable++;
          we_din = DDRAM_DIN; we_be = DDRAM_BE; we_run++;
        end
        if (!DDRAM_BUSY) begin
          acc_q.push_back(cmd_t'{DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_WE, DDRAM_DIN, DDRAM_BE});
          we_run = 0;
          if (DDRAM_WE) begin
            ddr_mem[DDRAM_ADDR] = merge(ddr_rd(DDRAM_ADDR), DDRAM_DIN, DDRAM_BE);
            done_cnt++;
          end else begin
            for (int i = 0; i < int'(DDRAM_BURSTCNT); i++)
              rq.push_back(ddr_rd(DDRAM_ADDR + 29'(i)));
          end
        end
      end else we_run = 0;
      if (p0_ack) begin grants.push_back(0); grant_cyc.push_back(cyc); end
      if (p1_ack) begin grants.push_back(1); grant_cyc.push_back(cyc); end
      ack_cycles += int'(p0_ack) + int'(p1_ack);
      if (p0_valid) begin
        p0_beats.push_back(p0_data);
        p0_dones.push_back(p0_done);
        if (p0_done) begin done_cnt++; p0_done_cyc = cyc; end
      end else if (p0_done) stray_done++;
      if (p1_valid) begin p1_beats.push_back(p1_dout); done_cnt++; end
      @(posedge clk); #1;
      if (busy_cnt > 0 && (DDRAM_RD || DDRAM_WE)) begin
        DDRAM_BUSY = 1'b1; busy_cnt--;
      end else DDRAM_BUSY = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (junk_ready > 0) begin
        junk_ready--; DDRAM_DOUT_READY = 1'b1; DDRAM_DOUT = {$urandom, $urandom};
      end else if (rq.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
        DDRAM_DOUT_READY = 1'b1; DDRAM_DOUT = rq.pop_front();
      end else DDRAM_DOUT_READY = 1'b0;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic clear_log();
    p0_beats.delete(); p0_dones.delete(); p1_beats.delete(); grants.delete();
    grant_cyc.delete(); acc_q.delete();
    ack_cycles = 0; rd_cycles = 0; we_cycles = 0; we_unstable = 0; stray_done = 0;
  endtask

  task automatic run_p0(input logic [28:0] a, input logic [7:0] l, output bit ok);
    int d0 = done_cnt;
    int g0 = grants.size();
    p0_addr = a; p0_len = l; p0_req = 1'b1; ok = 0;
    for (int t = 0; t < 300; t++) begin step(); if (grants.size() > g0) begin ok = 1; break; end end
    p0_req = 1'b0;
    if (ok) begin
      ok = 0;
      for (int t = 0; t < 800; t++) begin if (done_cnt > d0) begin ok = 1; break; end step(); end
    end
    m_streak = 0;
  endtask

  task automatic run_p1(input logic we, input logic [28:0] a, input logic [63:0] din,
                        input logic [7:0] be, output bit ok);
    int d0 = done_cnt;
    int g0 = grants.size();
    p1_we = we; p1_addr = a; p1_din = din; p1_be = be; p1_req = 1'b1; ok = 0;
    for (int t = 0; t < 300; t++) begin step(); if (grants.size() > g0) begin ok = 1; break; end end
    p1_req = 1'b0;
    if (ok) begin
      ok = 0;
      for (int t = 0; t < 800; t++) begin if (done_cnt > d0) begin ok = 1; break; end step(); end
    end
    if (we) ref_mem[a] = merge(ref_rd(a), din, be);
    m_streak = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    p0_req = 1'b1; p0_addr = 29'h55; p0_len = 8'd3;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_din = '0; p1_be = '0;
    repeat (4) step();
    checks++;
    if ({p0_ack, p0_valid, p0_done, p1_ack, p1_valid, DDRAM_RD, DDRAM_WE} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {p0_ack, p0_valid, p0_done, p1_ack, p1_valid, DDRAM_RD, DDRAM_WE});
    end
    checks++;
    if (DDRAM_BURSTCNT !== 8'd1) begin
      errors++; $display("FAIL reset_burstcnt: got %0d, required 1", DDRAM_BURSTCNT);
    end
    checks++;
    if ({p0_data, p1_dout, DDRAM_DIN, DDRAM_ADDR, DDRAM_BE} !== '0) begin
      errors++; $display("FAIL reset_data: got nonzero data/addr/be, required all 0");
    end
    checks++;
    if (grants.size() != 0) begin
      errors++; $display("FAIL reset_no_grant: got %0d grants, required 0", grants.size());
    end
    p0_req = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_p0_read();
    bit ok;
    rand_busy = 0; rand_gap = 0;
    clear_log();
    run_p0(29'h100, 8'd4, ok);
    repeat (3) step();
    checks++;
    if (!ok) begin errors++; $display("FAIL p0_read_timeout: got no completion, required p0_done"); end
    checks++;
    if (ack_cycles != 1 || grants.size() != 1) begin
      errors++; $display("FAIL p0_read_ack: got %0d ack cycles, required 1", ack_cycles);
    end
    checks++;
    if (rd_cycles != 1) begin errors++; $display("FAIL p0_read_rd_cycles: got %0d, required 1", rd_cycles); end
    checks++;
    if (acc_q.size() != 1 || acc_q[0].addr !== 29'h100 || acc_q[0].cnt !== 8'd4 || acc_q[0].be !== 8'hFF) begin
      errors++; $display("FAIL p0_read_cmd: got %0d commands, required one at 0x100 cnt 4 be ff", acc_q.size());
    end
    checks++;
    if (p0_beats.size() != 4) begin
      errors++; $display("FAIL p0_read_beats: got %0d, required 4", p0_beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (p0_beats[i] !== ref_rd(29'h100 + 29'(i)) || p0_dones[i] !== (i == 3)) begin
          errors++;
          $display("FAIL p0_read_beat%0d: got %h done=%0d, required %h done=%0d",
                   i, p0_beats[i], p0_dones[i], ref_rd(29'h100 + 29'(i)), (i == 3));
        end
      end
    end
  endtask

  task automatic test_p1_write_busy();
    bit ok;
    rand_busy = 0;
    clear_log();
    busy_cnt = 3;
    run_p1(1'b1, 29'h2000, 64'hDEADBEEF, 8'h0F, ok);
    busy_cnt = 0;
    repeat (6) step();
    checks++;
    if (!ok) begin errors++; $display("FAIL p1_write_timeout: got no acceptance, required one"); end
    checks++;
    if (we_cycles != 4 || we_unstable != 0) begin
      errors++; $display("FAIL p1_write_hold: got %0d WE cycles (%0d unstable), required 4 (0)", we_cycles, we_unstable);
    end
    checks++;
    if (acc_q.size() != 1 || acc_q[0].din !== 64'hDEADBEEF || acc_q[0].be !== 8'h0F ||
        acc_q[0].cnt !== 8'd1 || acc_q[0].addr !== 29'h2000 || acc_q[0].we !== 1'b1) begin
      errors++; $display("FAIL p1_write_cmd: got %0d commands, required one write din deadbeef be 0f", acc_q.size());
    end
    checks++;
    if (p1_beats.size() != 0 || rd_cycles != 0) begin
      errors++; $display("FAIL p1_write_no_valid: got %0d p1_valid, %0d RD cycles, required 0", p1_beats.size(), rd_cycles);
    end
  endtask

  task automatic test_p1_read();
    bit ok;
    clear_log();
    run_p1(1'b0, 29'h2000, 64'h0, 8'h00, ok);
    repeat (3) step();
    checks++;
    if (!ok || p1_beats.size() != 1) begin
      errors++; $display("FAIL p1_read_count: got %0d beats, required 1", p1_beats.size());
    end else begin
      checks++;
      if (p1_beats[0] !== merge(init_word(29'h2000), 64'hDEADBEEF, 8'h0F)) begin
        errors++; $display("FAIL p1_read_data: got %h, required %h", p1_beats[0],
                           merge(init_word(29'h2000), 64'hDEADBEEF, 8'h0F));
      end
    end
    checks++;
    if (acc_q.size() != 1 || acc_q[0].be !== 8'hFF || acc_q[0].cnt !== 8'd1 || p0_beats.size() != 0) begin
      errors++; $display("FAIL p1_read_cmd: got %0d commands / %0d p0 beats, required 1 read be ff cnt 1 / 0", acc_q.size(), p0_beats.size());
    end
  endtask

  task automatic test_len0();
    bit ok;
    logic [28:0] a = 29'($urandom_range(0, 4095)) + 29'h8000;
    clear_log();
    run_p0(a, 8'd0, ok);
    repeat (4) step();
    checks++;
    if (acc_q.size() != 1 || acc_q[0].cnt !== 8'd1) begin
      errors++; $display("FAIL len0_burstcnt: got %0d commands, required one with cnt 1", acc_q.size());
    end
    checks++;
    if (!ok || p0_beats.size() != 1 || p0_dones[0] !== 1'b1 || p0_beats[0] !== ref_rd(a)) begin
      errors++; $display("FAIL len0_beats: got %0d beats, required exactly 1 with done", p0_beats.size());
    end
  endtask

  task automatic test_simultaneous();
    bit ok = 0;
    int d0 = done_cnt;
    clear_log();
    rand_busy = 1; rand_gap = 1;
    p0_addr = 29'h400; p0_len = 8'd2;
    p1_we = 1'b0; p1_addr = 29'h500;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int t = 0; t < 1500; t++) begin
      step();
      if (grants.size() > 0 && grants[0] == 0) p0_req = 1'b0;
      if (grants.size() > 0 && grants[$] == 1) p1_req = 1'b0;
      if (done_cnt >= d0 + 2) begin ok = 1; break; end
    end
    p0_req = 1'b0; p1_req = 1'b0; m_streak = 0;
    checks++;
    if (!ok || grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
      errors++; $display("FAIL simul_order: got %0d grants (first %0d), required p0 then p1",
                         grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end else begin
      checks++;
      if (grant_cyc[1] <= p0_done_cyc) begin
        errors++; $display("FAIL simul_p1_after_done: got p1 ack cycle %0d, required after %0d", grant_cyc[1], p0_done_cyc);
      end
    end
    checks++;
    if (p0_beats.size() != 2 || p1_beats.size() != 1 ||
        p0_beats[0] !== ref_rd(29'h400) || p0_beats[1] !== ref_rd(29'h401) || p1_beats[0] !== ref_rd(29'h500)) begin
      errors++; $display("FAIL simul_data: got %0d p0 / %0d p1 beats, required 2 / 1 with matching data",
                         p0_beats.size(), p1_beats.size());
    end
  endtask

  task automatic test_starvation();
    int exp_q[$];
    int s = m_streak;
    bit p1p = 1;
    bit ok = 0;
    int d0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      if (p1p && s == P0_STREAK) begin exp_q.push_back(1); s = 0; p1p = 0; end
      else begin exp_q.push_back(0); s = p1p ? ((s < P0_STREAK) ? s + 1 : s) : 0; end
    end
    clear_log();
    p0_addr = 29'h600; p0_len = 8'd1;
    p1_we = 1'b0; p1_addr = 29'h700;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      step();
      if (grants.size() > 0 && grants[$] == 1) p1_req = 1'b0;
      if (grants.size() >= 6) p0_req = 1'b0;
      if (done_cnt >= d0 + 6) begin ok = 1; break; end
    end
    p0_req = 1'b0; p1_req = 1'b0; m_streak = 0;
    checks++;
    if (!ok || grants.size() != 6) begin
      errors++; $display("FAIL starve_count: got %0d grants, required 6", grants.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grants[k] != exp_q[k]) begin
          errors++; $display("FAIL starve_grant%0d: got port %0d, required port %0d", k, grants[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok = 0;
    clear_log();
    p0_addr = 29'h900; p0_len = 8'd8; p0_req = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      step();
      if (grants.size() > 0) p0_req = 1'b0;
      if (p0_beats.size() >= 2) begin ok = 1; break; end
    end
    p0_req = 1'b0;
    reset = 1'b1;
    step(); step();
    checks++;
    if (!ok || {p0_valid, p0_done, p1_valid, DDRAM_RD, DDRAM_WE, p0_ack, p1_ack} !== 7'd0 ||
        DDRAM_BURSTCNT !== 8'd1 || p0_data !== 64'd0) begin
      errors++; $display("FAIL midreset_outputs: got burstcnt %0d valid %b, required burstcnt 1 and all 0",
                         DDRAM_BURSTCNT, p0_valid);
    end
    reset = 1'b0;
    junk_ready = 6;
    repeat (12) step();
    checks++;
    if (p0_beats.size() != 2 || p1_beats.size() != 0 || stray_done != 0 || p0_dones[1] !== 1'b0) begin
      errors++; $display("FAIL midreset_no_valid: got %0d p0 / %0d p1 beats after reset, required 2 / 0",
                         p0_beats.size(), p1_beats.size());
    end
    m_streak = 0;
    clear_log();
    run_p0(29'hA00, 8'd3, ok);
    repeat (3) step();
    checks++;
    if (!ok || p0_beats.size() != 3 || p0_dones[2] !== 1'b1 || p0_beats[2] !== ref_rd(29'hA02) ||
        p0_beats[0] !== ref_rd(29'hA00)) begin
      errors++; $display("FAIL midreset_recover: got %0d beats, required 3 ending with done", p0_beats.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    rand_busy = 1; rand_gap = 1;
    for (int it = 0; it < 24; it++) begin
      logic [28:0] a = 29'h3000 + 29'($urandom_range(0, 7));
      clear_log();
      if ($urandom_range(0, 1) == 0) begin
        logic [7:0] l = 8'($urandom_range(0, 6));
        int n = (l == 0) ? 1 : int'(l);
        run_p0(a, l, ok);
        repeat (2) step();
        checks++;
        if (!ok || p0_beats.size() != n || p0_dones[n-1] !== 1'b1) begin
          errors++; $display("FAIL rand%0d_p0_count: got %0d beats, required %0d", it, p0_beats.size(), n);
        end else begin
          for (int i = 0; i < n; i++) begin
            checks++;
            if (p0_beats[i] !== ref_rd(a + 29'(i))) begin
              errors++; $display("FAIL rand%0d_p0_beat%0d: got %h, required %h", it, i, p0_beats[i], ref_rd(a + 29'(i)));
            end
          end
        end
      end else begin
        logic        we  = 1'($urandom_range(0, 1));
        logic [63:0] din = {$urandom, $urandom};
        logic [7:0]  be  = 8'($urandom_range(1, 255));
        logic [63:0] exp_rd = ref_rd(a);
        run_p1(we, a, din, be, ok);
        repeat (2) step();
        checks++;
        if (!ok || acc_q.size() != 1 || acc_q[0].addr !== a || acc_q[0].we !== we) begin
          errors++; $display("FAIL rand%0d_p1_cmd: got %0d commands, required one at %h we=%0d", it, acc_q.size(), a, we);
        end else if (we) begin
          checks++;
          if (acc_q[0].din !== din || acc_q[0].be !== be || p1_beats.size() != 0) begin
            errors++; $display("FAIL rand%0d_p1_write: got din %h be %h, required din %h be %h",
                               it, acc_q[0].din, acc_q[0].be, din, be);
          end
        end else begin
          checks++;
          if (p1_beats.size() != 1 || p1_beats[0] !== exp_rd) begin
            errors++; $display("FAIL rand%0d_p1_read: got %0d beats, required 1 equal to %h", it, p1_beats.size(), exp_rd);
          end
        end
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_p0_read();
    test_p1_write_busy();
    test_p1_read();
    test_len0();
    test_simultaneous();
    test_starvation();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddram_arb.md
DDRAM_ARB -- requirements
Module: ddram_arb

Interface
REQ-001 SHALL have parameter: P0_STREAK, 4, maximum consecutive port-0 grants while port-1 is waiting.
REQ-002 SHALL have port: clk  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: p0_req  in  1  video burst-read request, level-held until p0_ack.
REQ-005 SHALL have port: p0_addr  in  29  port-0 burst start address in 64-bit words.
REQ-006 SHALL have port: p0_len  in  8  port-0 burst length in beats; 0 means 1.
REQ-007 SHALL have port: p0_ack  out  1  one-cycle grant pulse for port 0.
REQ-008 SHALL have port: p0_data  out  64  port-0 read beat.
REQ-009 SHALL have port: p0_valid  out  1  qualifies p0_data.
REQ-010 SHALL have port: p0_done  out  1  pulses together with the final p0_valid of a burst.
REQ-011 SHALL have port: p1_req  in  1  general single-word request, level-held until p1_ack.
REQ-012 SHALL have port: p1_we  in  1  1 = write, 0 = read.
REQ-013 SHALL have port: p1_addr  in  29  port-1 word address.
REQ-014 SHALL have port: p1_din  in  64  port-1 write data.
REQ-015 SHALL have port: p1_be  in  8  port-1 byte enables.
REQ-016 SHALL have port: p1_ack  out  1  one-cycle grant pulse for port 1.
REQ-017 SHALL have port: p1_dout  out  64  port-1 read data.
REQ-018 SHALL have port: p1_valid  out  1  qualifies p1_dout.
REQ-019 SHALL have DDRAM ports: DDRAM_BUSY in 1, DDRAM_DOUT in 64, DDRAM_DOUT_READY in 1, DDRAM_BURSTCNT out 8, DDRAM_ADDR out 29, DDRAM_DIN out 64, DDRAM_BE out 8, DDRAM_RD out 1, DDRAM_WE out 1.

Function
REQ-020 SHALL implement states IDLE, CMD and RDATA.
REQ-021 In IDLE, the arbiter SHALL grant port 0 if p0_req is high, except that port 1 SHALL win when p1_req is high and streak == P0_STREAK.
REQ-022 If only p1_req is high in IDLE, the arbiter SHALL grant port 1.
REQ-023 On a grant, the arbiter SHALL latch address, length, write flag, data and byte enables, and SHALL move to CMD on the next edge.
REQ-024 The p0_ack or p1_ack pulse SHALL be high only during the first CMD cycle.
REQ-025 In CMD, the arbiter SHALL drive all DDRAM command outputs from registers and SHALL hold them until it samples DDRAM_BUSY low with RD or WE high (acceptance).
REQ-026 For port-0 grants, DDRAM_BURSTCNT SHALL equal p0_len, or 1 when p0_len is 0.
REQ-027 For port-1 grants, DDRAM_BURSTCNT SHALL be 1.
REQ-028 DDRAM_BE SHALL be 8'hFF for reads.
REQ-029 At acceptance, a write SHALL go to IDLE and a read SHALL go to RDATA; RD and WE SHALL be low from the next cycle.
REQ-030 In RDATA, each DDRAM_DOUT_READY SHALL produce p0_valid/p0_data or p1_valid/p1_dout (owner-routed), registered one cycle later.
REQ-031 The arbiter SHALL return to IDLE after the beat count reaches BURSTCNT; p0_done SHALL coincide with the last p0_valid.
REQ-032 DDRAM_DOUT_READY outside RDATA SHALL be ignored.
REQ-033 The streak counter SHALL increment on a port-0 grant while p1_req is high, saturating at P0_STREAK.
REQ-034 The streak counter SHALL clear on any port-1 grant, and on a port-0 grant while p1_req is low.
REQ-035 The arbiter SHALL hold at most one outstanding transaction; request-line changes outside IDLE SHALL be ignored.

Reset
REQ-036 While reset is high, the block SHALL be in IDLE with streak=0, and every output SHALL be 0 except DDRAM_BURSTCNT=1.
REQ-037 Reset mid-burst SHALL discard remaining beats, and no valid or done SHALL be emitted afterwards.

Verification
REQ-038 p0 read: p0_req, addr=0x100, len=4, BUSY=0 -> p0_ack 1 cycle, RD with BURSTCNT=4 and ADDR=0x100 for one cycle, 4 p0_valid, p0_done on the 4th.
REQ-039 p1 write under busy: p1_we=1, din=0xDEADBEEF, be=0x0F, BUSY high for 3 cycles -> WE held for 4 cycles with stable DIN/BE, then IDLE, and no p1_valid.
REQ-040 Simultaneous requests: p0_req and p1_req both high in IDLE -> p0 granted first, then p1 after the p0 burst completes if p0_req has dropped.
REQ-041 Starvation: p0_req permanently high and p1_req high, P0_STREAK=4 -> grant order p0, p0, p0, p0, p1, then p0 resumes.
REQ-042 p0_len=0 -> BURSTCNT=1, exactly one p0_valid together with p0_done.
REQ-043 Reset asserted after 2 of 8 beats -> outputs go to reset values, later DOUT_READY pulses produce no valid, and the next request is served normally.
